z80_io_port_controller: RTL and testbench
=========================================

Name: z80_io_port_controller

Overview:
- I/O-side peripheral that sits directly downstream of the Z80 data bus steering block.
- Consumes the CPU write byte (data_to_io) and bus strobes during I/O cycles; produces the read byte (data_from_io) for I/O reads and the IM2 vector during interrupt acknowledge.
- Holds a small register bank: interrupt enable, pending, vector base, GPIO out/in.
- Generates the active-low INT request to the CPU from edge-detected interrupt sources.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..8).
- BASE_ADDR, 8'h80, I/O port of register 0; registers occupy BASE_ADDR..BASE_ADDR+4.
- IDLE_DATA, 8'hFF, data_from_io value for unmapped ports and idle bus.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ioreq  in  1  Z80 IORQ_n, active low
- m1  in  1  Z80 M1_n, active low
- rd  in  1  Z80 RD_n, active low
- wr  in  1  Z80 WR_n, active low
- addr  in  8  Z80 A[7:0], port number
- data_to_io  in  8  CPU write byte from the bus steering block
- data_from_io  out  8  read byte / IM2 vector to the bus steering block
- irq_src  in  NUM_IRQ  interrupt sources, synchronous to clk, rising-edge triggered
- int_n  out  1  Z80 INT_n, active low
- gpio_in  in  8  general input port
- gpio_out  out  8  general output latch

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high; all state updates on posedge clk.
- Reset values: int_n=1, data_from_io=IDLE_DATA, gpio_out=0, ien=0, pend=0, vbase=0, all edge-detect history=0.
- Cycle qualifiers, sampled each clk:
  - iow = !ioreq & m1 & !wr & rd
  - ior = !ioreq & m1 & !rd & wr
  - ack = !ioreq & !m1
- Register map (offset = addr-BASE_ADDR; other addr unmapped):
  - 0 IEN: RW, bits [NUM_IRQ-1:0]
  - 1 PEND: read status; write 1s to clear
  - 2 VBASE: RW, only [7:4] stored, reads back {VBASE,4'b0}
  - 3 GPIO_OUT: RW
  - 4 GPIO_IN: RO, writes ignored
  - Unimplemented bits read 0.
- Writes:
  - Commit on the first clk where iow is true and was false the previous clk: exactly one commit per I/O cycle, however long the cycle.
  - Writes to unmapped ports are ignored.
- Reads:
  - data_from_io is registered. While ior holds with a mapped addr, it loads the selected register each clk; 1-cycle latency.
  - Unmapped addr, or no ior/ack: data_from_io <= IDLE_DATA.
- Pending:
  - pend[i] sets on a rising edge of irq_src[i] (registered previous value), regardless of IEN.
  - If a set and a PEND write-clear of the same bit occur in the same clk, set wins.
- Priority: lowest index is highest. sel = lowest i with pend[i] & ien[i].
- Interrupt state machine, states IDLE, REQ, ACK:
  - IDLE: if |(pend & ien) then int_n<=0, go REQ.
  - REQ: int_n stays 0. If (pend & ien) becomes 0 (cleared by software or IEN write), int_n<=1, go IDLE. On ack rising edge: latch idx=sel, clear pend[idx], int_n<=1, data_from_io<={vbase,idx[2:0],1'b0}, go ACK.
  - ACK: hold data_from_io at the vector until ack deasserts, then data_from_io<=IDLE_DATA and go IDLE. A new request is re-evaluated from IDLE next clk.
  - Ack in IDLE (spurious): drive vector {vbase,3'b111,1'b0}, go ACK, clear nothing.
  - A source edge during ACK sets pend; it is serviced after return to IDLE.
- Reset mid-cycle (during REQ/ACK or an I/O write): all state returns to reset values; an in-flight write is not committed.
- gpio_out is registered, updated only by a GPIO_OUT write.

Decomposition:
- Shared package z80_io_pkg:
  - register offsets REG_IEN=0, REG_PEND=1, REG_VBASE=2, REG_GPIO_OUT=3, REG_GPIO_IN=4
  - interrupt state enum {IDLE,REQ,ACK}
  - SPURIOUS_IDX=3'b111
- One sub-module: z80_irq_prio_encoder. Combinational lowest-index-first encoder over pend & ien; outputs valid and idx[2:0].

Test Plan:
- After reset -> int_n=1, data_from_io=8'hFF, gpio_out=8'h00. Read port 8'h80 -> 8'h00.
- I/O write 8'hA5 to port 8'h83, held 6 clks -> gpio_out=8'hA5 after exactly one commit. Read 8'h83 -> 8'hA5 one clk after ior asserts.
- Write IEN=8'h0C, VBASE=8'h40. Pulse irq_src[3] then irq_src[2] -> int_n=0. Ack cycle -> data_from_io=8'h44, pend=8'h08, int_n=1. Second ack -> 8'h46.
- irq_src[1] edge with IEN=0 -> PEND reads 8'h02, int_n stays 1. Write PEND=8'h02 -> PEND reads 8'h00.
- Same-clk PEND write-clear of bit 5 and irq_src[5] rising edge -> PEND bit 5 remains 1.
- Assert reset while in ACK -> next clk int_n=1, data_from_io=8'hFF, pend=0.

Source files
------------

// File: rtl/z80_io_pkg.sv
// Shared definitions for the Z80 I/O port controller: register offsets,
// interrupt FSM encoding and the IM2 vector format.
package z80_io_pkg;

    localparam logic [2:0] REG_IEN      = 3'd0;
    localparam logic [2:0] REG_PEND     = 3'd1;
    localparam logic [2:0] REG_VBASE    = 3'd2;
    localparam logic [2:0] REG_GPIO_OUT = 3'd3;
    localparam logic [2:0] REG_GPIO_IN  = 3'd4;

    localparam logic [2:0] SPURIOUS_IDX = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } irq_state_e;

    function automatic logic [7:0] im2_vector(input logic [3:0] vbase,
                                              input logic [2:0] idx);
        return {vbase, idx, 1'b0};
    endfunction

endpackage

// File: rtl/z80_irq_prio_encoder.sv
// Lowest-index-first priority encoder over the enabled pending sources.
module z80_irq_prio_encoder #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [2:0]         idx_o
);

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/z80_io_port_controller.sv
// Z80 I/O peripheral: IEN/PEND/VBASE/GPIO register bank, registered read
// path and IM2 interrupt request/acknowledge sequencing.
module z80_io_port_controller
    import z80_io_pkg::*;
#(
    parameter int         NUM_IRQ   = 8,
    parameter logic [7:0] BASE_ADDR = 8'h80,
    parameter logic [7:0] IDLE_DATA = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ioreq,
    input  logic               m1,
    input  logic               rd,
    input  logic               wr,
    input  logic [7:0]         addr,
    input  logic [7:0]         data_to_io,
    output logic [7:0]         data_from_io,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic               int_n,
    input  logic [7:0]         gpio_in,
    output logic [7:0]         gpio_out
);

    logic               iow, ior, ack;
    logic               iow_q, ack_q;
    logic               wr_commit, ack_rise;
    logic [7:0]         offset;
    logic               mapped;
    logic [2:0]         reg_sel;

    logic [NUM_IRQ-1:0] ien_q, ien_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] irq_rise, wr_clr, ack_clr;
    logic [3:0]         vbase_q, vbase_d;
    logic [7:0]         gpio_q, gpio_d;
    logic [7:0]         dout_q, dout_d;
    logic [7:0]         rd_data;
    logic               int_n_q, int_n_d;
    irq_state_e         state_q, state_d;

    logic               prio_valid;
    logic [2:0]         prio_idx;

    assign iow = !ioreq &&  m1 && !wr &&  rd;
    assign ior = !ioreq &&  m1 && !rd &&  wr;
    assign ack = !ioreq && !m1;

    assign offset  = addr - BASE_ADDR;
    assign reg_sel = offset[2:0];
    assign mapped  = (offset[7:3] == 5'd0) && (reg_sel <= REG_GPIO_IN);

    // A write is taken once, on the first clock of the I/O cycle.
    assign wr_commit = iow && !iow_q && mapped;
    assign ack_rise  = ack && !ack_q;
    assign irq_rise  = irq_src & ~irq_prev_q;

    z80_irq_prio_encoder #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req_i   (pend_q & ien_q),
        .valid_o (prio_valid),
        .idx_o   (prio_idx)
    );

    always_comb begin
        rd_data = 8'h00;
        case (reg_sel)
            REG_IEN:      rd_data = 8'(ien_q);
            REG_PEND:     rd_data = 8'(pend_q);
            REG_VBASE:    rd_data = {vbase_q, 4'b0000};
            REG_GPIO_OUT: rd_data = gpio_q;
            REG_GPIO_IN:  rd_data = gpio_in;
            default:      rd_data = 8'h00;
        endcase
    end

    always_comb begin
        ien_d   = ien_q;
        vbase_d = vbase_q;
        gpio_d  = gpio_q;
        wr_clr  = '0;
        if (wr_commit) begin
            case (reg_sel)
                REG_IEN:      ien_d   = data_to_io[NUM_IRQ-1:0];
                REG_PEND:     wr_clr  = data_to_io[NUM_IRQ-1:0];
                REG_VBASE:    vbase_d = data_to_io[7:4];
                REG_GPIO_OUT: gpio_d  = data_to_io;
                default:      ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        int_n_d = int_n_q;
        ack_clr = '0;
        dout_d  = (ior && mapped) ? rd_data : IDLE_DATA;
        case (state_q)
            IDLE: begin
                if (ack_rise) begin
                    dout_d  = im2_vector(vbase_q, SPURIOUS_IDX);
                    int_n_d = 1'b1;
                    state_d = ACK;
                end else if (prio_valid) begin
                    int_n_d = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A request that vanished exactly as the ack arrived still
                // gets an answer: the spurious vector.
                if (ack_rise) begin
                    if (prio_valid) begin
                        dout_d  = im2_vector(vbase_q, prio_idx);
                        ack_clr = NUM_IRQ'(1) << prio_idx;
                    end else begin
                        dout_d  = im2_vector(vbase_q, SPURIOUS_IDX);
                    end
                    int_n_d = 1'b1;
                    state_d = ACK;
                end else if (!prio_valid) begin
                    int_n_d = 1'b1;
                    state_d = IDLE;
                end
            end
            ACK: begin
                int_n_d = 1'b1;
                if (ack) begin
                    dout_d = dout_q;
                end else begin
                    dout_d  = IDLE_DATA;
                    state_d = IDLE;
                end
            end
            default: begin
                int_n_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // New edges win over any clear landing in the same clock.
    assign pend_d = (pend_q & ~(wr_clr | ack_clr)) | irq_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            iow_q      <= 1'b0;
            ack_q      <= 1'b0;
            ien_q      <= '0;
            pend_q     <= '0;
            irq_prev_q <= '0;
            vbase_q    <= 4'h0;
            gpio_q     <= 8'h00;
            dout_q     <= IDLE_DATA;
            int_n_q    <= 1'b1;
            state_q    <= IDLE;
        end else begin
            iow_q      <= iow;
            ack_q      <= ack;
            ien_q      <= ien_d;
            pend_q     <= pend_d;
            irq_prev_q <= irq_src;
            vbase_q    <= vbase_d;
            gpio_q     <= gpio_d;
            dout_q     <= dout_d;
            int_n_q    <= int_n_d;
            state_q    <= state_d;
        end
    end

    assign data_from_io = dout_q;
    assign int_n        = int_n_q;
    assign gpio_out     = gpio_q;

endmodule

// File: tb/tb_z80_io_port_controller.sv
// Directed + randomized bench for z80_io_port_controller against a
// transaction-level register/interrupt model.
module tb_z80_io_port_controller;

    localparam int         NIRQ = 8;
    localparam logic [7:0] BASE = 8'h80;

    logic            clk = 1'b0;
    logic            reset;
    logic            ioreq, m1, rd, wr;
    logic [7:0]      addr, dto, dfrom;
    logic [NIRQ-1:0] irq_src;
    logic            int_n;
    logic [7:0]      gpio_in, gpio_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_ien, m_pend, m_vbase, m_gpio;

    z80_io_port_controller #(.NUM_IRQ(NIRQ), .BASE_ADDR(BASE), .IDLE_DATA(8'hFF)) dut (
        .clk          (clk),
        .reset        (reset),
        .ioreq        (ioreq),
        .m1           (m1),
        .rd           (rd),
        .wr           (wr),
        .addr         (addr),
        .data_to_io   (dto),
        .data_from_io (dfrom),
        .irq_src      (irq_src),
        .int_n        (int_n),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        ioreq = 1'b1; m1 = 1'b1; rd = 1'b1; wr = 1'b1;
    endtask

    task automatic model_reset();
        m_ien = 8'h00; m_pend = 8'h00; m_vbase = 8'h00; m_gpio = 8'h00;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] off;
        off = a - BASE;
        case (off)
            8'd0: m_ien   = d;
            8'd1: m_pend  = m_pend & ~d;
            8'd2: m_vbase = d & 8'hF0;
            8'd3: m_gpio  = d;
            default: ;
        endcase
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic [7:0] off;
        off = a - BASE;
        case (off)
            8'd0:    return m_ien;
            8'd1:    return m_pend;
            8'd2:    return m_vbase;
            8'd3:    return m_gpio;
            8'd4:    return gpio_in;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int hold);
        addr = a; dto = d; ioreq = 1'b0; wr = 1'b0;
        repeat (hold) tick();
        bus_idle();
        tick();
        model_write(a, d);
    endtask

    task automatic io_read(input string tag, input logic [7:0] a);
        addr = a; ioreq = 1'b0; rd = 1'b0;
        chk({tag, "_pre"}, dfrom, 8'hFF);
        tick();
        chk(tag, dfrom, model_read(a));
        bus_idle();
        tick();
        chk({tag, "_idle"}, dfrom, 8'hFF);
    endtask

    task automatic irq_pulse(input int i);
        irq_src[i] = 1'b1;
        tick();
        irq_src[i] = 1'b0;
        tick();
        m_pend[i] = 1'b1;
    endtask

    task automatic settle_check(input string tag);
        tick();
        tick();
        chk(tag, {7'b0, int_n}, {7'b0, ((m_pend & m_ien) == 8'h00)});
    endtask

    task automatic ack_cycle(input string tag);
        logic [7:0] live, exp;
        int idx;
        live = m_pend & m_ien;
        idx = 7;
        for (int i = NIRQ - 1; i >= 0; i--) if (live[i]) idx = i;
        if (live != 8'h00) begin
            exp = m_vbase + 8'(idx * 2);
            m_pend[idx] = 1'b0;
        end else begin
            exp = m_vbase + 8'h0E;
        end
        ioreq = 1'b0; m1 = 1'b0;
        tick();
        chk(tag, dfrom, exp);
        chk({tag, "_intn"}, {7'b0, int_n}, 8'h01);
        tick();
        chk({tag, "_hold"}, dfrom, exp);
        bus_idle();
        tick();
        chk({tag, "_rel"}, dfrom, 8'hFF);
    endtask

    initial begin
        logic [7:0] a, d;
        int op;

        reset = 1'b1; bus_idle(); addr = 8'h00; dto = 8'h00;
        irq_src = '0; gpio_in = 8'h3C;
        model_reset();
        repeat (2) tick();
        chk("rst_intn", {7'b0, int_n}, 8'h01);
        chk("rst_dout", dfrom, 8'hFF);
        chk("rst_gpio", gpio_out, 8'h00);
        reset = 1'b0;
        tick();
        io_read("rd_ien0", 8'h80);

        // Long write: one commit, data visible on GPIO_OUT and read path.
        io_write(8'h83, 8'hA5, 6);
        chk("gpio_a5", gpio_out, 8'hA5);
        io_read("rd_gpio", 8'h83);

        // Long PEND write-clear; an edge mid-cycle must survive (no recommit).
        addr = 8'h81; dto = 8'h01; ioreq = 1'b0; wr = 1'b0;
        tick();
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        repeat (3) tick();
        bus_idle();
        tick();
        m_pend[0] = 1'b1;
        io_read("one_commit", 8'h81);
        io_write(8'h81, 8'h01, 1);

        io_write(8'h80, 8'h0C, 1);
        io_write(8'h82, 8'h40, 1);
        irq_pulse(3);
        irq_pulse(2);
        settle_check("intn_req");
        ack_cycle("vec_44");
        io_read("pend_08", 8'h81);
        settle_check("intn_req2");
        ack_cycle("vec_46");
        settle_check("intn_done");

        irq_pulse(1);
        settle_check("intn_masked");
        io_read("pend_02", 8'h81);
        io_write(8'h81, 8'h02, 1);
        io_read("pend_00", 8'h81);

        // Same-clock write-clear and rising edge on bit 5: set wins.
        irq_pulse(5);
        addr = 8'h81; dto = 8'h20; ioreq = 1'b0; wr = 1'b0; irq_src[5] = 1'b1;
        tick();
        irq_src[5] = 1'b0;
        bus_idle();
        tick();
        io_read("set_wins", 8'h81);

        ack_cycle("spurious");
        settle_check("intn_spur");
        io_read("unmapped", 8'h85);
        io_write(8'h84, 8'h99, 2);
        gpio_in = 8'h5A;
        io_read("gpio_in_ro", 8'h84);
        io_write(8'h82, 8'hFF, 1);
        io_read("vbase_low0", 8'h82);

        for (int n = 0; n < 150; n++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    a = (($urandom_range(0, 5) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 4)));
                    d = 8'($urandom);
                    io_write(a, d, int'($urandom_range(1, 4)));
                end
                1: begin
                    a = (($urandom_range(0, 5) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 4)));
                    gpio_in = 8'($urandom);
                    io_read("rnd_rd", a);
                end
                2: irq_pulse(int'($urandom_range(0, NIRQ - 1)));
                default: ack_cycle("rnd_ack");
            endcase
            settle_check("rnd_intn");
            chk("rnd_gpio", gpio_out, m_gpio);
        end

        // Reset while acknowledging.
        io_write(8'h80, 8'hFF, 1);
        irq_pulse(6);
        settle_check("pre_rst_req");
        ioreq = 1'b0; m1 = 1'b0;
        tick();
        reset = 1'b1;
        bus_idle();
        tick();
        chk("rst_ack_intn", {7'b0, int_n}, 8'h01);
        chk("rst_ack_dout", dfrom, 8'hFF);
        reset = 1'b0;
        model_reset();
        tick();
        io_read("rst_pend", 8'h81);
        io_read("rst_ien", 8'h80);
        chk("rst_gpio2", gpio_out, 8'h00);
        settle_check("rst_intn2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
